// File: rtl/line_drawer_arbiter.sv
// line_drawer_arbiter: shares one line drawer between NUM_REQ segment
// requesters. Each requester owns a pending bit and a coordinate latch; the
// FSM picks pending slots round-robin and hands the segment to the drawer.
module line_drawer_arbiter #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int NUM_REQ           = 2,
   localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
   localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS),
   localparam int G_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ*X_WIDTH-1:0]   req_x1,
   input  logic [NUM_REQ*Y_WIDTH-1:0]   req_y1,
   input  logic [NUM_REQ*X_WIDTH-1:0]   req_x2,
   input  logic [NUM_REQ*Y_WIDTH-1:0]   req_y2,
   input  logic [NUM_REQ-1:0]           req_start,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [X_WIDTH-1:0]           x1,
   output logic [Y_WIDTH-1:0]           y1,
   output logic [X_WIDTH-1:0]           x2,
   output logic [Y_WIDTH-1:0]           y2,
   output logic                         line_drawer_start,
   input  logic                         line_drawer_ready,
   output logic [G_WIDTH-1:0]           grant,
   output logic                         busy
);

   typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;

   state_t               state_q;
   logic [X_WIDTH-1:0]   x1_q, x2_q;
   logic [Y_WIDTH-1:0]   y1_q, y2_q;
   logic                 start_q;
   logic [G_WIDTH-1:0]   grant_q;
   logic [G_WIDTH-1:0]   last_grant_q;

   logic [X_WIDTH-1:0]   slot_x1_q [NUM_REQ];
   logic [Y_WIDTH-1:0]   slot_y1_q [NUM_REQ];
   logic [X_WIDTH-1:0]   slot_x2_q [NUM_REQ];
   logic [Y_WIDTH-1:0]   slot_y2_q [NUM_REQ];
   logic                 pending_q [NUM_REQ];
   logic                 ready_q   [NUM_REQ];

   logic [NUM_REQ-1:0]   pending_vec;
   logic                 complete_d;
   logic [G_WIDTH-1:0]   winner_d;
   int                   idx;

   // The granted segment finishes when the drawer reports ready in WAIT2.
   assign complete_d = (state_q == WAIT2) && line_drawer_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
         assign pending_vec[gi] = pending_q[gi];
         assign req_ready[gi]   = ready_q[gi];

         // Slot capture on an accepted strobe; release when its line completes.
         always_ff @(posedge clk) begin
            if (rst) begin
               pending_q[gi] <= 1'b0;
               ready_q[gi]   <= 1'b1;
            end else if (req_start[gi] && ready_q[gi]) begin
               slot_x1_q[gi] <= req_x1[gi*X_WIDTH +: X_WIDTH];
               slot_y1_q[gi] <= req_y1[gi*Y_WIDTH +: Y_WIDTH];
               slot_x2_q[gi] <= req_x2[gi*X_WIDTH +: X_WIDTH];
               slot_y2_q[gi] <= req_y2[gi*Y_WIDTH +: Y_WIDTH];
               pending_q[gi] <= 1'b1;
               ready_q[gi]   <= 1'b0;
            end else if (complete_d && (grant_q == G_WIDTH'(gi))) begin
               pending_q[gi] <= 1'b0;
               ready_q[gi]   <= 1'b1;
            end
         end
      end
   endgenerate

   // Round-robin pick: nearest pending slot after last_grant. Scanning from the
   // farthest offset down lets the closest candidate overwrite the others.
   always_comb begin
      winner_d = last_grant_q;
      idx      = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_grant_q) + k) % NUM_REQ;
         if (pending_vec[G_WIDTH'(idx)]) begin
            winner_d = G_WIDTH'(idx);
         end
      end
   end

   // Issue/wait FSM with registered drawer-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         x1_q         <= '0;
         y1_q         <= '0;
         x2_q         <= '0;
         y2_q         <= '0;
         start_q      <= 1'b0;
         grant_q      <= '0;
         last_grant_q <= G_WIDTH'(NUM_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if ((|pending_vec) && line_drawer_ready) begin
                  x1_q    <= slot_x1_q[winner_d];
                  y1_q    <= slot_y1_q[winner_d];
                  x2_q    <= slot_x2_q[winner_d];
                  y2_q    <= slot_y2_q[winner_d];
                  start_q <= 1'b1;
                  grant_q <= winner_d;
                  state_q <= WAIT1;
               end
            end
            WAIT1: begin
               // Drawer ready is ignored here to ride over its one-cycle drop.
               start_q <= 1'b0;
               state_q <= WAIT2;
            end
            WAIT2: begin
               if (line_drawer_ready) begin
                  last_grant_q <= grant_q;
                  state_q      <= IDLE;
               end
            end
            default: begin
               start_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign x1                = x1_q;
   assign y1                = y1_q;
   assign x2                = x2_q;
   assign y2                = y2_q;
   assign line_drawer_start = start_q;
   assign grant             = grant_q;
   assign busy              = (state_q != IDLE);

endmodule
